// File: rtl/mul_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mul_result_stage
//  Description : Final carry-propagate stage of the radix-4 Booth multiplier.
//                Resolves sum + (carry << 1) mod 2^PW over two pipeline
//                stages and returns the low or high XLEN-bit word over a
//                valid/ready interface.
//                Optional feature macro: MULRES_CNT_EN (completed-op counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_result_stage #(
    parameter int PW   = 64,
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PW-1:0]   in_sum,
    input  logic [PW-1:0]   in_carry,
    input  logic [1:0]      in_op,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    output logic [31:0]     done_cnt
);

    localparam logic [1:0] c_OP_MUL = 2'b00;

    // Stage-1 pipeline registers
    logic            r_s1_valid;
    logic [XLEN-1:0] r_s1_lo;
    logic            r_s1_c;
    logic [XLEN-1:0] r_s1_sum_hi;
    logic [XLEN-1:0] r_s1_cs_hi;
    logic [1:0]      r_s1_op;
    logic [TAGW-1:0] r_s1_tag;

    // Stage-2 (output) registers
    logic            r_s2_valid;
    logic [XLEN-1:0] r_out_result;
    logic [TAGW-1:0] r_out_tag;

    logic [PW-1:0]   w_cs;
    logic [XLEN:0]   w_lo_sum;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_s2_result;
    logic            w_s2_adv;
    logic            w_in_acc;
    logic            w_out_fire;
    logic            w_unused_carry_msb;

    // Carry vector shifted into place; its top bit falls off (mod 2^PW).
    assign w_cs               = {in_carry[PW-2:0], 1'b0};
    assign w_unused_carry_msb = in_carry[PW-1];

    // Low-half add with carry-out, computed on the incoming operands.
    assign w_lo_sum = {1'b0, in_sum[XLEN-1:0]} + {1'b0, w_cs[XLEN-1:0]};

    // High-half add completes the split using the registered low carry.
    assign w_hi = r_s1_sum_hi + r_s1_cs_hi + {{(XLEN-1){1'b0}}, r_s1_c};

    // MUL returns the low word; all MULH variants return the high word.
    assign w_s2_result = (r_s1_op == c_OP_MUL) ? r_s1_lo : w_hi;

    // Handshake / advance control
    assign w_s2_adv   = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = !r_s1_valid || w_s2_adv;
    assign w_in_acc   = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    // Stage-1 occupancy: flush kills, accept fills, advance empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_acc) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage-1 datapath, load-enabled on accept only.
    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_s1_lo     <= w_lo_sum[XLEN-1:0];
            r_s1_c      <= w_lo_sum[XLEN];
            r_s1_sum_hi <= in_sum[PW-1:XLEN];
            r_s1_cs_hi  <= w_cs[PW-1:XLEN];
            r_s1_op     <= in_op;
            r_s1_tag    <= in_tag;
        end
    end

    // Stage-2 occupancy: flush kills, advance fills, consumer pop empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= 1'b1;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Stage-2 result/tag; held stable while stalled because w_s2_adv is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else if (w_s2_adv) begin
            r_out_result <= w_s2_result;
            r_out_tag    <= r_s1_tag;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

`ifdef MULRES_CNT_EN
    logic [31:0] r_done_cnt;

    // Count every delivered result; survives flush, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_cnt <= 32'd0;
        end else if (w_out_fire) begin
            r_done_cnt <= r_done_cnt + 32'd1;
        end
    end

    assign done_cnt = r_done_cnt;
`else
    logic w_unused_out_fire;

    assign w_unused_out_fire = w_out_fire;
    assign done_cnt          = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_result_stage
//  Description : Self-checking scoreboard bench for mul_result_stage.
//                Honors MULRES_CNT_EN for the completed-op counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_result_stage;

    localparam int PW   = 64;
    localparam int XLEN = 32;
    localparam int TAGW = 5;

`ifdef MULRES_CNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_sum;
    logic [PW-1:0]   in_carry;
    logic [1:0]      in_op;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [TAGW-1:0] out_tag;
    logic [31:0]     done_cnt;

    exp_t        sb_q[$];
    int          n_tests;
    int          n_fail;
    logic [31:0] exp_cnt;

    mul_result_stage #(.PW(PW), .XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a result is handshaken.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_cnt <= exp_cnt + 32'd1;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got tag %0d result 0x%0h with nothing expected",
                         out_tag, out_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", {32'd0, out_result}, {32'd0, e.res});
                check("tag", {59'd0, out_tag}, {59'd0, e.tag});
            end
        end
    end

    // Present one op and hold it until accepted; expectation pushed on accept.
    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [1:0] op,
                        input logic [4:0] tag, input logic [31:0] exp_res);
        int waits;
        in_sum   = s;
        in_carry = c;
        in_op    = op;
        in_tag   = tag;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: tag %0d never accepted", tag);
                in_valid = 1'b0;
                return;
            end
        end
        sb_q.push_back('{res: exp_res, tag: tag});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while (sb_q.size() != 0 && waits < 200) begin
            @(posedge clk);
            waits++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        exp_cnt = 32'd0;
        rst = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_cnt   = 32'd0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        in_op     = 2'b00;
        in_tag    = '0;
        out_ready = 1'b1;

        do_reset();
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        check("rst_done_cnt", {32'd0, done_cnt}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Carry crosses the split; every op variant resolves to 1.
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 5'd1, 32'h0000_0001);
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b11, 5'd2, 32'h0000_0001);
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b01, 5'd3, 32'h0000_0001);
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b10, 5'd4, 32'h0000_0001);
        // Carry MSB is discarded.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b01, 5'd5, 32'hFFFF_FFFF);
        // Generic patterns, no carry across the split.
        send(64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0001, 2'b00, 5'd6, 32'h9ABC_DEF2);
        send(64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0001, 2'b10, 5'd7, 32'h1234_567A);
        // cs = 0xFFFF_FFFF_FFFF_FFFE (product -2).
        send(64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 2'b00, 5'd8, 32'hFFFF_FFFE);
        send(64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01, 5'd9, 32'hFFFF_FFFF);
        drain();
        check("cnt_after_9", {32'd0, done_cnt}, {32'd0, (c_CNT_EN ? exp_cnt : 32'd0)});

        // Backpressure: third op must stall, then all three emerge in order.
        out_ready = 1'b0;
        send(64'h10, 64'h0, 2'b00, 5'd11, 32'h0000_0010);
        send(64'h20, 64'h0, 2'b00, 5'd12, 32'h0000_0020);
        in_sum   = 64'h30;
        in_carry = 64'h0;
        in_op    = 2'b00;
        in_tag   = 5'd13;
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        check("stall_out_tag", {59'd0, out_tag}, 64'd11);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(64'h30, 64'h0, 2'b00, 5'd13, 32'h0000_0030);
        drain();

        // Flush with two ops in flight and a new op offered in the flush cycle.
        out_ready = 1'b0;
        send(64'h40, 64'h0, 2'b00, 5'd14, 32'h0000_0040);
        send(64'h50, 64'h0, 2'b00, 5'd15, 32'h0000_0050);
        in_sum   = 64'h60;
        in_tag   = 5'd16;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        send(64'h0000_0002_0000_0003, 64'h0000_0000_0000_0002, 2'b11, 5'd17, 32'h0000_0002);
        drain();
        check("cnt_before_rst", {32'd0, done_cnt}, {32'd0, (c_CNT_EN ? exp_cnt : 32'd0)});

        // Reset mid-operation drops the in-flight op and clears the counter.
        out_ready = 1'b0;
        send(64'h70, 64'h0, 2'b00, 5'd18, 32'h0000_0070);
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst2_done_cnt", {32'd0, done_cnt}, 64'd0);
        @(posedge clk);
        #1;
        send(64'h5, 64'h2, 2'b00, 5'd19, 32'h0000_0009);
        drain();
        check("cnt_after_rst", {32'd0, done_cnt}, {32'd0, (c_CNT_EN ? 32'd1 : 32'd0)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
